// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// type, default operand width and the legal operand-width range.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int MULT_WIDTH_DEFAULT = 4;
    localparam int MULT_WIDTH_MIN     = 2;
    localparam int MULT_WIDTH_MAX     = 32;

endpackage

// File: rtl/mult_cond_adder.sv
// WIDTH-bit conditional adder: sum = b + (en ? a : 0), carry kept in the
// extra MSB. One instance serves every iteration of the shift-add loop.
module mult_cond_adder
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH-1:0] addend;

    // Gate the multiplicand and form the carry-preserving sum
    always_comb begin
        addend = en ? a : '0;
        sum    = {1'b0, b} + {1'b0, addend};
    end

endmodule

// File: rtl/seq_array_multiplier.sv
// Iterative shift-add multiplier with valid/ready handshakes on both sides.
// One WIDTH-bit conditional adder is reused over WIDTH cycles; the multiplier
// lives in the lower half of the combined accumulator and is shifted out as
// partial sums shift in from the top.
//
// Optional feature macro: MULT_SIGNED_EN
//   When defined, the sgn port exists. With sgn = 1 the operands are treated
//   as two's complement: magnitudes are multiplied unsigned and the full
//   product is negated when it is loaded into the output register.
module seq_array_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_EN
    input  logic               sgn,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    if ((WIDTH < MULT_WIDTH_MIN) || (WIDTH > MULT_WIDTH_MAX)) begin : g_width_check
        $error("seq_array_multiplier: WIDTH out of legal range");
    end

    mult_state_t      state;
    mult_state_t      state_next;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_shift;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] count;
    logic             neg;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             neg_in;
    logic             last_iter;
    logic [PW-1:0]    product_reg;

    // Two's-complement negate of the full-width product when requested
    function automatic logic [PW-1:0] negate_if(input logic [PW-1:0] v,
                                                input logic en);
        return en ? -v : v;
    endfunction

`ifdef MULT_SIGNED_EN
    // Magnitude of a WIDTH-bit operand; -2^(WIDTH-1) maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    // Convert signed operands to magnitudes plus a result sign
    always_comb begin
        a_mag  = magnitude(a, sgn);
        b_mag  = magnitude(b, sgn);
        neg_in = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
    end
`else
    // Unsigned-only build: operands pass straight through
    always_comb begin
        a_mag  = a;
        b_mag  = b;
        neg_in = 1'b0;
    end
`endif

    // Add the multiplicand into the upper half when the multiplier LSB is set
    mult_cond_adder #(
        .WIDTH (WIDTH)
    ) u_cond_adder (
        .en  (acc[0]),
        .a   (mcand),
        .b   (acc[PW-1:WIDTH]),
        .sum (sum)
    );

    // Shift {carry, acc} right by one; the consumed multiplier bit drops out
    always_comb begin
        acc_shift = {sum, acc[WIDTH-1:1]};
        last_iter = (count == LAST_ITER);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs, decoded from registered state only
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, iteration and product load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            mcand       <= '0;
            count       <= '0;
            neg         <= 1'b0;
            product_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= a_mag;
                        acc   <= {{WIDTH{1'b0}}, b_mag};
                        count <= '0;
                        neg   <= neg_in;
                    end
                end
                RUN: begin
                    acc   <= acc_shift;
                    count <= count + CNT_W'(1);
                    // Only the finished product ever reaches the output
                    if (last_iter) begin
                        product_reg <= negate_if(acc_shift, neg);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = product_reg;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Self-checking bench for seq_array_multiplier at WIDTH=4 and WIDTH=16.
// Expected products come from plain integer multiplication.
module tb_seq_array_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        vld4, rdy4, ov4, or4, busy4, sgn4;
    logic [3:0]  a4, b4;
    logic [7:0]  prod4;
    logic        vld16, rdy16, ov16, or16, busy16, sgn16;
    logic [15:0] a16, b16;
    logic [31:0] prod16;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [7:0]  last4;
    logic [31:0] last16;

    seq_array_multiplier #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (vld4),
        .in_ready  (rdy4),
        .a         (a4),
        .b         (b4),
`ifdef MULT_SIGNED_EN
        .sgn       (sgn4),
`endif
        .out_valid (ov4),
        .out_ready (or4),
        .product   (prod4),
        .busy      (busy4)
    );

    seq_array_multiplier #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (vld16),
        .in_ready  (rdy16),
        .a         (a16),
        .b         (b16),
`ifdef MULT_SIGNED_EN
        .sgn       (sgn16),
`endif
        .out_valid (ov16),
        .out_ready (or16),
        .product   (prod16),
        .busy      (busy16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model4(input logic [3:0] x, input logic [3:0] y, input logic s);
        int ix = int'(x);
        int iy = int'(y);
        if (s) begin
            if (x[3]) ix -= 16;
            if (y[3]) iy -= 16;
        end
        return 8'(ix * iy);
    endfunction

    function automatic logic [31:0] model16(input logic [15:0] x, input logic [15:0] y, input logic s);
        longint ix = longint'(x);
        longint iy = longint'(y);
        if (s) begin
            if (x[15]) ix -= 65536;
            if (y[15]) iy -= 65536;
        end
        return 32'(ix * iy);
    endfunction

    // One WIDTH=4 transaction; hold = cycles out_ready stays low once out_valid is up
    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_, input logic ts, input int hold);
        int cyc;
        logic [7:0] exp;
        exp = model4(ta, tb_, ts);
        cyc = 0;
        while (!rdy4 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("w4_ready_at_issue", 64'(rdy4), 64'(1));
        or4  = (hold == 0);
        a4   = ta;
        b4   = tb_;
        sgn4 = ts;
        vld4 = 1'b1;
        tick();
        vld4 = 1'b0;
        a4   = 4'($urandom);
        b4   = 4'($urandom);
        sgn4 = 1'($urandom);
        cyc = 0;
        while (!ov4 && cyc < 40) begin
            check("w4_run_product_hold", 64'(prod4), 64'(last4));
            check("w4_run_flags", 64'({rdy4, busy4}), 64'(2'b01));
            tick();
            cyc++;
        end
        check("w4_latency", 64'(cyc), 64'(4));
        check("w4_product", 64'(prod4), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            vld4 = 1'($urandom);
            a4   = 4'($urandom);
            b4   = 4'($urandom);
            tick();
            check("w4_bp_product", 64'(prod4), 64'(exp));
            check("w4_bp_flags", 64'({ov4, rdy4, busy4}), 64'(3'b101));
        end
        vld4 = 1'b0;
        or4  = 1'b1;
        tick();
        check("w4_release_flags", 64'({ov4, rdy4, busy4}), 64'(3'b010));
        check("w4_release_product", 64'(prod4), 64'(exp));
        last4 = exp;
    endtask

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_, input logic ts);
        int cyc;
        logic [31:0] exp;
        exp = model16(ta, tb_, ts);
        cyc = 0;
        while (!rdy16 && cyc < 40) begin
            tick();
            cyc++;
        end
        a16   = ta;
        b16   = tb_;
        sgn16 = ts;
        vld16 = 1'b1;
        tick();
        vld16 = 1'b0;
        a16   = 16'($urandom);
        b16   = 16'($urandom);
        cyc = 0;
        while (!ov16 && cyc < 60) begin
            tick();
            cyc++;
        end
        check("w16_latency", 64'(cyc), 64'(16));
        check("w16_product", 64'(prod16), 64'(exp));
        tick();
        check("w16_idle", 64'({ov16, rdy16}), 64'(2'b01));
        last16 = exp;
    endtask

    initial begin
        rst_n = 1'b0;
        vld4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; sgn4 = 1'b0;
        vld16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; sgn16 = 1'b0;
        last4 = '0;
        last16 = '0;
        repeat (3) tick();
        check("rst_w4_flags", 64'({rdy4, ov4, busy4}), 64'(3'b100));
        check("rst_w4_product", 64'(prod4), 64'(0));
        check("rst_w16_flags", 64'({rdy16, ov16, busy16}), 64'(3'b100));
        check("rst_w16_product", 64'(prod16), 64'(0));
        rst_n = 1'b1;
        tick();

        run4(4'd15, 4'd15, 1'b0, 0);
        check("w4_15x15", 64'(prod4), 64'(8'hE1));
        run4(4'd0, 4'd13, 1'b0, 0);
        check("w4_0x13", 64'(prod4), 64'(8'h00));
        run4(4'd9, 4'd1, 1'b0, 0);
        check("w4_9x1", 64'(prod4), 64'(8'h09));

        run4(4'd7, 4'd6, 1'b0, 10);
        check("w4_bp_7x6", 64'(prod4), 64'(8'h2A));

        a4 = 4'd11; b4 = 4'd13; sgn4 = 1'b0; vld4 = 1'b1;
        tick();
        vld4 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrun_rst_flags", 64'({rdy4, ov4, busy4}), 64'(3'b100));
        check("midrun_rst_product", 64'(prod4), 64'(0));
        #1;
        rst_n = 1'b1;
        last4 = '0;
        last16 = '0;
        tick();
        run4(4'd3, 4'd5, 1'b0, 0);
        check("w4_after_rst_3x5", 64'(prod4), 64'(8'h0F));

        for (int i = 0; i < 256; i++) begin
`ifdef MULT_SIGNED_EN
            run4(4'(i >> 4), 4'(i), 1'($urandom), int'($urandom_range(0, 2)));
`else
            run4(4'(i >> 4), 4'(i), 1'b0, int'($urandom_range(0, 2)));
`endif
        end

`ifdef MULT_SIGNED_EN
        run4(4'h8, 4'h8, 1'b1, 0);
        check("s_m8xm8", 64'(prod4), 64'(8'h40));
        run4(4'h8, 4'h7, 1'b1, 0);
        check("s_m8x7", 64'(prod4), 64'(8'hC8));
        run4(4'hF, 4'h5, 1'b1, 0);
        check("s_m1x5", 64'(prod4), 64'(8'hFB));
        run4(4'h8, 4'h8, 1'b0, 0);
        check("u_8x8", 64'(prod4), 64'(8'h40));
`endif

        run16(16'hFFFF, 16'hFFFF, 1'b0);
        check("w16_max", 64'(prod16), 64'(32'hFFFE0001));
        run16(16'd255, 16'd255, 1'b0);
        check("w16_255x255", 64'(prod16), 64'(32'h0000FE01));
        for (int i = 0; i < 1000; i++) begin
`ifdef MULT_SIGNED_EN
            run16(16'($urandom), 16'($urandom), 1'($urandom));
`else
            run16(16'($urandom), 16'($urandom), 1'b0);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
